mmu_accum: RTL and testbench

// - Downstream of the systolic MMU. Captures each column's bottom-row partial sum, removes the
//   1-cycle-per-column output skew, and accumulates 3-wide result vectors into an addressed buffer.
// - On command, drains a buffer range to the activation/store stage over valid/ready, clearing each entry.

---
 rtl/mmu_pkg.sv | 32 +++
 rtl/mmu_accum_deskew.sv | 66 ++++++
 rtl/mmu_accum.sv | 169 ++++++++++++++++
 tb/tb_mmu_accum.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and arithmetic for the MMU accumulator slice.
// Build option: define ACC_SAT_EN to saturate accumulate overflows instead of wrapping.
package mmu_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int ARRAY_SIZE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } accum_state_t;

    // Returns {overflow, sum}; overflow means both operands share a sign the result lacks.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
        sum = a + b;
        ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
`ifdef ACC_SAT_EN
        if (ovf) begin
            sum = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`else
        sum = sum;
`endif
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/mmu_accum_deskew.sv
// Removes the per-column output skew of the systolic array: lane c gets ARRAY_SIZE-1-c alignment
// registers plus one common output register; valid/addr/accum travel in a matching side pipe.
module mmu_accum_deskew #(
    parameter int ACC_WIDTH  = mmu_pkg::ACC_WIDTH,
    parameter int ARRAY_SIZE = mmu_pkg::ARRAY_SIZE,
    parameter int ADDR_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ACC_WIDTH*ARRAY_SIZE-1:0] lane_in,
    input  logic                          valid_in,
    input  logic [ADDR_W-1:0]             addr_in,
    input  logic                          accum_in,
    output logic [ACC_WIDTH*ARRAY_SIZE-1:0] lane_out,
    output logic                          valid_out,
    output logic [ADDR_W-1:0]             addr_out,
    output logic                          accum_out
);

    genvar gi;

    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
        localparam int NST = ARRAY_SIZE - gi;
        logic [ACC_WIDTH-1:0] dly_reg [NST];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NST; k++) dly_reg[k] <= '0;
            end else begin
                dly_reg[0] <= lane_in[gi*ACC_WIDTH +: ACC_WIDTH];
                for (int k = 1; k < NST; k++) dly_reg[k] <= dly_reg[k-1];
            end
        end

        assign lane_out[gi*ACC_WIDTH +: ACC_WIDTH] = dly_reg[NST-1];
    end

    // Side pipe is as long as lane 0's path, so it lines up with the aligned vector.
    logic              valid_pipe_reg [ARRAY_SIZE];
    logic              accum_pipe_reg [ARRAY_SIZE];
    logic [ADDR_W-1:0] addr_pipe_reg  [ARRAY_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ARRAY_SIZE; k++) begin
                valid_pipe_reg[k] <= 1'b0;
                accum_pipe_reg[k] <= 1'b0;
                addr_pipe_reg[k]  <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= valid_in;
            accum_pipe_reg[0] <= accum_in;
            addr_pipe_reg[0]  <= addr_in;
            for (int k = 1; k < ARRAY_SIZE; k++) begin
                valid_pipe_reg[k] <= valid_pipe_reg[k-1];
                accum_pipe_reg[k] <= accum_pipe_reg[k-1];
                addr_pipe_reg[k]  <= addr_pipe_reg[k-1];
            end
        end
    end

    assign valid_out = valid_pipe_reg[ARRAY_SIZE-1];
    assign accum_out = accum_pipe_reg[ARRAY_SIZE-1];
    assign addr_out  = addr_pipe_reg[ARRAY_SIZE-1];

endmodule

// File: rtl/mmu_accum.sv
// MMU output accumulator: deskews column psums, accumulates vectors into an addressed buffer and
// drains buffer ranges over valid/ready with clear-on-read. Build option: ACC_SAT_EN (saturating add).
module mmu_accum
    import mmu_pkg::*;
#(
    parameter int ACC_WIDTH  = mmu_pkg::ACC_WIDTH,
    parameter int ARRAY_SIZE = mmu_pkg::ARRAY_SIZE,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ACC_WIDTH*ARRAY_SIZE-1:0] psum_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ADDR_W-1:0]               in_addr,
    input  logic                            in_accum,
    input  logic                            drain_start,
    input  logic [ADDR_W-1:0]               drain_base,
    input  logic [ADDR_W:0]                 drain_len,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_WIDTH*ARRAY_SIZE-1:0] out_data,
    output logic [ADDR_W-1:0]               out_addr,
    output logic                            out_last,
    output logic                            drain_done,
    output logic                            acc_ovf
);

    localparam int VEC_W = ACC_WIDTH * ARRAY_SIZE;
    localparam int LEN_W = ADDR_W + 1;
    localparam int FC_W  = $clog2(ARRAY_SIZE + 1);

    accum_state_t state_reg, state_next;

    logic [VEC_W-1:0]  buf_mem [DEPTH];
    logic [VEC_W-1:0]  al_data;
    logic              al_valid;
    logic [ADDR_W-1:0] al_addr;
    logic              al_accum;
    logic [VEC_W-1:0]  rmw_data;
    logic [ARRAY_SIZE-1:0] lane_ovf;

    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [LEN_W-1:0]  left_reg;
    logic [LEN_W-1:0]  len_clamped;
    logic [FC_W-1:0]   flush_cnt_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic [VEC_W-1:0]  out_data_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic              acc_ovf_reg;

    logic start_acc;
    logic handshake;
    logic flush_end;

    assign in_ready    = (state_reg == IDLE);
    assign start_acc   = in_ready && drain_start;
    assign handshake   = out_valid_reg && out_ready;
    assign flush_end   = (state_reg == FLUSH) && (flush_cnt_reg == FC_W'(ARRAY_SIZE - 1));
    assign len_clamped = (drain_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : drain_len;

    mmu_accum_deskew #(
        .ACC_WIDTH (ACC_WIDTH),
        .ARRAY_SIZE(ARRAY_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_deskew (
        .clk      (clk),
        .rst_n    (rst_n),
        .lane_in  (psum_in),
        .valid_in (in_valid && in_ready),
        .addr_in  (in_addr),
        .accum_in (in_accum),
        .lane_out (al_data),
        .valid_out(al_valid),
        .addr_out (al_addr),
        .accum_out(al_accum)
    );

    // Read-modify-write straight off the flop array; consecutive hits on one entry need no forwarding.
    genvar gi;
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_rmw
        logic [ACC_WIDTH:0] add_res;
        assign add_res = sat_add(buf_mem[al_addr][gi*ACC_WIDTH +: ACC_WIDTH],
                                 al_data[gi*ACC_WIDTH +: ACC_WIDTH]);
        assign rmw_data[gi*ACC_WIDTH +: ACC_WIDTH] =
            al_accum ? add_res[ACC_WIDTH-1:0] : al_data[gi*ACC_WIDTH +: ACC_WIDTH];
        assign lane_ovf[gi] = al_accum && add_res[ACC_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (drain_start) state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = (left_reg == '0) ? DONE : DRAIN;
            DRAIN:   if (handshake && out_last_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
        end else begin
            if (al_valid) buf_mem[al_addr] <= rmw_data;
            if (handshake) buf_mem[out_addr_reg] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg    <= '0;
            left_reg      <= '0;
            flush_cnt_reg <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
            acc_ovf_reg   <= 1'b0;
        end else begin
            if (start_acc) begin
                rd_ptr_reg    <= drain_base;
                left_reg      <= len_clamped;
                flush_cnt_reg <= '0;
            end else if (state_reg == FLUSH) begin
                flush_cnt_reg <= flush_cnt_reg + FC_W'(1);
            end

            // Next beat is fetched when the output register is empty or being consumed.
            if ((state_reg == DRAIN) && (!out_valid_reg || handshake)) begin
                if (left_reg != '0) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= buf_mem[rd_ptr_reg];
                    out_addr_reg  <= rd_ptr_reg;
                    out_last_reg  <= (left_reg == LEN_W'(1));
                    rd_ptr_reg    <= rd_ptr_reg + ADDR_W'(1);
                    left_reg      <= left_reg - LEN_W'(1);
                end else begin
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            end

            if (al_valid && (|lane_ovf)) begin
                acc_ovf_reg <= 1'b1;
            end else if (start_acc) begin
                acc_ovf_reg <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_addr   = out_addr_reg;
    assign out_last   = out_last_reg;
    assign drain_done = (state_reg == DONE);
    assign acc_ovf    = acc_ovf_reg;

endmodule

// File: tb/tb_mmu_accum.sv
// Directed scoreboard bench for mmu_accum: stimulus pushes expected drain beats, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_mmu_accum;

    localparam int W     = 32;
    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int VW    = W * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] psum_in;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          in_accum;
    logic          drain_start;
    logic [AW-1:0] drain_base;
    logic [AW:0]   drain_len;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          drain_done;
    logic          acc_ovf;

    always #5 clk = ~clk;

    mmu_accum #(.ACC_WIDTH(W), .ARRAY_SIZE(N), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_accum(in_accum), .drain_start(drain_start), .drain_base(drain_base),
        .drain_len(drain_len), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .drain_done(drain_done), .acc_ovf(acc_ovf)
    );

    typedef struct {
        logic [VW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    beat_t        exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           done_cnt = 0;
    int           beat_cnt = 0;
    logic [W-1:0] pend [8][N];
    int           ptr = 0;
    bit           toggle_rdy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drain_done) done_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got addr %0d data %0h, expected no beat", out_addr, out_data);
                end else begin
                    chk($sformatf("beat_addr%0d", exp_q[0].addr),
                        128'({out_last, out_addr, out_data}),
                        128'({exp_q[0].last, exp_q[0].addr, exp_q[0].data}));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beat_cnt++;
                    end
                end
            end
        end
    end

    // Advance one cycle; lanes 1..N-1 of earlier vectors emerge from the skew schedule.
    task automatic tick();
        @(posedge clk);
        #1;
        ptr = (ptr + 1) % 8;
        psum_in = {pend[ptr][2], pend[ptr][1], pend[ptr][0]};
        for (int c = 0; c < N; c++) pend[ptr][c] = '0;
        in_valid    = 1'b0;
        drain_start = 1'b0;
        out_ready   = toggle_rdy ? ~out_ready : 1'b1;
    endtask

    task automatic issue(input int addr, input bit acc, input logic [W-1:0] l0, l1, l2);
        chk("in_ready_at_issue", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_addr  = addr[AW-1:0];
        in_accum = acc;
        psum_in[W-1:0] = l0;
        pend[(ptr + 1) % 8][1] = l1;
        pend[(ptr + 2) % 8][2] = l2;
    endtask

    task automatic drain_req(input int base, input int len);
        drain_start = 1'b1;
        drain_base  = base[AW-1:0];
        drain_len   = len[AW:0];
    endtask

    task automatic expect_beat(input int addr, input logic [W-1:0] d0, d1, d2, input bit last);
        beat_t b;
        b.data = {d2, d1, d0};
        b.addr = addr[AW-1:0];
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input string name);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < 80) begin
            tick();
            k++;
        end
        chk({name, "_done"}, 128'(done_cnt - start), 128'(1));
        chk({name, "_beats_left"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ovf_lane;
        int start_beats;
        int k;
        int saved_done;

        in_valid = 0; in_addr = 0; in_accum = 0; psum_in = 0;
        drain_start = 0; drain_base = 0; drain_len = 0; out_ready = 1;
        for (int s = 0; s < 8; s++) for (int c = 0; c < N; c++) pend[s][c] = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",   128'(in_ready),   128'(1));
        chk("rst_out_valid",  128'(out_valid),  128'(0));
        chk("rst_out_last",   128'(out_last),   128'(0));
        chk("rst_drain_done", 128'(drain_done), 128'(0));
        chk("rst_acc_ovf",    128'(acc_ovf),    128'(0));
        rst_n = 1'b1;
        tick();

        // Overwrite then accumulate.
        issue(5, 0, 1, 2, 3);      tick();
        issue(5, 1, 10, 20, 30);   tick();
        repeat (4) tick();
        chk("no_false_ovf", 128'(acc_ovf), 128'(0));
        expect_beat(5, 11, 22, 33, 1);
        drain_req(5, 1); tick();
        chk("flush_in_ready", 128'(in_ready), 128'(0));
        wait_done("t1");

        // Back-to-back accumulation into one entry, then clear-on-read.
        issue(0, 0, 0, 0, 0); tick();
        repeat (4) begin issue(0, 1, 1, 1, 1); tick(); end
        repeat (4) tick();
        expect_beat(0, 4, 4, 4, 1);
        drain_req(0, 1); tick();
        wait_done("t2");
        expect_beat(0, 0, 0, 0, 1);
        drain_req(0, 1); tick();
        wait_done("t2_clear");

        // Signed overflow.
        issue(2, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF); tick();
        issue(2, 1, 1, 1, 1); tick();
        repeat (4) tick();
        chk("ovf_set", 128'(acc_ovf), 128'(1));
`ifdef ACC_SAT_EN
        ovf_lane = 32'h7FFF_FFFF;
`else
        ovf_lane = 32'h8000_0000;
`endif
        expect_beat(2, ovf_lane, ovf_lane, ovf_lane, 1);
        drain_req(2, 1); tick();
        chk("ovf_clear", 128'(acc_ovf), 128'(0));
        wait_done("t3");

        // Address wrap with toggling backpressure.
        issue(14, 0, 32'h14, 32'h140, 32'h1400); tick();
        issue(15, 0, 32'h15, 32'h150, 32'h1500); tick();
        issue(0,  0, 32'h20, 32'h200, 32'h2000); tick();
        issue(1,  0, 32'h21, 32'h210, 32'h2100); tick();
        repeat (4) tick();
        expect_beat(14, 32'h14, 32'h140, 32'h1400, 0);
        expect_beat(15, 32'h15, 32'h150, 32'h1500, 0);
        expect_beat(0,  32'h20, 32'h200, 32'h2000, 0);
        expect_beat(1,  32'h21, 32'h210, 32'h2100, 1);
        toggle_rdy = 1'b1;
        drain_req(14, 4); tick();
        wait_done("t4");
        toggle_rdy = 1'b0;
        tick();

        // Vector and drain_start together; flush window; drain_start during DRAIN ignored.
        issue(3, 0, 5, 6, 7);
        drain_req(3, 1);
        expect_beat(3, 5, 6, 7, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush%0d_in_ready", i),  128'(in_ready),  128'(0));
            chk($sformatf("flush%0d_out_valid", i), 128'(out_valid), 128'(0));
            tick();
        end
        drain_req(0, 2); tick();
        wait_done("t5");
        saved_done = done_cnt;
        repeat (8) tick();
        chk("ignored_start_no_done", 128'(done_cnt), 128'(saved_done));

        drain_req(0, 0); tick();
        wait_done("len0");

        // drain_len above DEPTH clamps to DEPTH.
        issue(7, 0, 32'h77, 32'h78, 32'h79); tick();
        repeat (4) tick();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 7) expect_beat(i, 32'h77, 32'h78, 32'h79, 0);
            else        expect_beat(i, 0, 0, 0, (i == DEPTH - 1));
        end
        drain_req(0, 20); tick();
        wait_done("clamp");

        // Reset in the middle of a drain.
        issue(8,  0, 8, 8, 8);     tick();
        issue(9,  0, 9, 9, 9);     tick();
        issue(10, 0, 10, 10, 10);  tick();
        issue(11, 0, 11, 11, 11);  tick();
        repeat (4) tick();
        expect_beat(8,  8, 8, 8, 0);
        expect_beat(9,  9, 9, 9, 0);
        expect_beat(10, 10, 10, 10, 0);
        expect_beat(11, 11, 11, 11, 1);
        drain_req(8, 4); tick();
        start_beats = beat_cnt;
        k = 0;
        while (beat_cnt < start_beats + 2 && k < 40) begin
            tick();
            k++;
        end
        chk("mid_drain_beats", 128'(beat_cnt - start_beats), 128'(2));
        saved_done = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready",  128'(in_ready),  128'(1));
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("midrst_no_done", 128'(done_cnt), 128'(saved_done));
        for (int i = 0; i < DEPTH; i++) expect_beat(i, 0, 0, 0, (i == DEPTH - 1));
        drain_req(0, 16); tick();
        wait_done("readback");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
